// File: rtl/dco_code_ctrl_pkg.sv
// Shared types and default constants for the ADPLL DCO code controller.
// Build option: DCO_CTRL_LOCK_LOSS_EN (see dco_lock_detect).
package adpll_pkg;

  typedef enum logic {ST_SEARCH, ST_TRACK} state_e;

  localparam int CODE_W_DEF   = 8;
  localparam int LOCK_CNT_DEF = 4;

  // Mid-scale start code and first binary-search step for the default width.
  localparam logic [CODE_W_DEF-1:0] MID_CODE  = {1'b1, {(CODE_W_DEF-1){1'b0}}};
  localparam logic [CODE_W_DEF-1:0] INIT_STEP = {2'b01, {(CODE_W_DEF-2){1'b0}}};

endpackage

// File: rtl/dco_code_ctrl_if.sv
// Detector-to-controller bundle: M pins, PD decision strobe, code/lock back.
interface dco_code_ctrl_if
  import adpll_pkg::*;
#(
  parameter int CODE_W = CODE_W_DEF
) ();

  logic              M2;
  logic              M1;
  logic              M0;
  logic              PD_VALID;
  logic              PD_FAST;
  logic [CODE_W-1:0] DCO_CODE;
  logic              LOCK;

  modport master (
    output M2, M1, M0, PD_VALID, PD_FAST,
    input  DCO_CODE, LOCK
  );

  modport slave (
    input  M2, M1, M0, PD_VALID, PD_FAST,
    output DCO_CODE, LOCK
  );

endinterface

// File: rtl/dco_lock_detect.sv
// Lock detector: counts consecutive direction alternations of TRACK decisions.
// DCO_CTRL_LOCK_LOSS_EN defined: lock follows the count; undefined: lock is sticky.
module dco_lock_detect
  import adpll_pkg::*;
#(
  parameter int LOCK_CNT = LOCK_CNT_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic dec_valid_i,
  input  logic dec_fast_i,
  output logic lock_o
);

  localparam int CNT_W = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_CNT);

  logic             prev_vld_q;
  logic             prev_fast_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             lock_q;

  // Next alternation count: first decision or a repeat restarts, a reversal counts up.
  always_comb begin
    cnt_d = cnt_q;
    if (dec_valid_i) begin
      if (!prev_vld_q || (dec_fast_i == prev_fast_q)) begin
        cnt_d = '0;
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Direction history, counter and lock flag; clear comes from an M change.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      prev_vld_q  <= 1'b0;
      prev_fast_q <= 1'b0;
      cnt_q       <= '0;
      lock_q      <= 1'b0;
    end else if (dec_valid_i) begin
      prev_vld_q  <= 1'b1;
      prev_fast_q <= dec_fast_i;
      cnt_q       <= cnt_d;
`ifdef DCO_CTRL_LOCK_LOSS_EN
      lock_q      <= (cnt_d == CNT_MAX);
`else
      lock_q      <= lock_q | (cnt_d == CNT_MAX);
`endif
    end
  end

  assign lock_o = lock_q;

endmodule

// File: rtl/dco_code_ctrl.sv
// ADPLL DCO code controller: binary search of the DCO code, then +/-1 tracking
// with lock detection. Build option: DCO_CTRL_LOCK_LOSS_EN (lock may drop).
module dco_code_ctrl
  import adpll_pkg::*;
#(
  parameter int CODE_W   = CODE_W_DEF,
  parameter int LOCK_CNT = LOCK_CNT_DEF
) (
  input  logic           REF_CLK,
  input  logic           RESET,
  dco_code_ctrl_if.slave bus
);

  localparam logic [CODE_W-1:0] MID   = {1'b1, {(CODE_W-1){1'b0}}};
  localparam logic [CODE_W-1:0] STEP0 = {2'b01, {(CODE_W-2){1'b0}}};
  localparam logic [CODE_W-1:0] ONE   = CODE_W'(1);
  localparam logic [CODE_W-1:0] ALL1  = '1;

  logic [2:0]        m_pins;
  logic [2:0]        m_q;
  state_e            state_q;
  logic [CODE_W-1:0] code_q;
  logic [CODE_W-1:0] step_q;
  logic              m_chg;
  logic              dec_track;
  logic              lock_w;

  assign m_pins    = {bus.M2, bus.M1, bus.M0};
  assign m_chg     = (m_pins != m_q);
  // An M change swallows a coincident decision, so the detector must not see it.
  assign dec_track = bus.PD_VALID && !m_chg && (state_q == ST_TRACK);

  // Search/track FSM; reset and M change both restart acquisition from mid-code.
  always_ff @(posedge REF_CLK) begin
    if (RESET || m_chg) begin
      m_q     <= m_pins;
      state_q <= ST_SEARCH;
      code_q  <= MID;
      step_q  <= STEP0;
    end else if (bus.PD_VALID) begin
      case (state_q)
        ST_SEARCH: begin
          code_q <= bus.PD_FAST ? (code_q - step_q) : (code_q + step_q);
          step_q <= step_q >> 1;
          if (step_q == ONE) state_q <= ST_TRACK;
        end
        ST_TRACK: begin
          if (bus.PD_FAST) begin
            if (code_q != '0) code_q <= code_q - ONE;
          end else begin
            if (code_q != ALL1) code_q <= code_q + ONE;
          end
        end
        default: state_q <= ST_SEARCH;
      endcase
    end
  end

  dco_lock_detect #(
    .LOCK_CNT (LOCK_CNT)
  ) u_lock (
    .clk_i       (REF_CLK),
    .rst_i       (RESET),
    .clr_i       (m_chg),
    .dec_valid_i (dec_track),
    .dec_fast_i  (bus.PD_FAST),
    .lock_o      (lock_w)
  );

  assign bus.DCO_CODE = code_q;
  assign bus.LOCK     = lock_w;

endmodule

// File: tb/tb_dco_code_ctrl.sv
// Self-checking bench for dco_code_ctrl: directed plan scenarios plus a
// randomized run against a behavioural model of search, track and lock.
module tb_dco_code_ctrl;

  localparam int CODE_W   = 8;
  localparam int LOCK_CNT = 4;
  localparam int CODE_MAX = (1 << CODE_W) - 1;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  dco_code_ctrl_if #(.CODE_W(CODE_W)) bus ();

  dco_code_ctrl #(
    .CODE_W   (CODE_W),
    .LOCK_CNT (LOCK_CNT)
  ) dut (
    .REF_CLK (clk),
    .RESET   (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int       mdl_code;
  int       mdl_step;
  bit       mdl_track;
  bit       mdl_sticky;
  bit       hist[$];
  bit [2:0] mdl_m;
  bit [2:0] cur_m;

  task automatic mdl_reset();
    mdl_code   = 1 << (CODE_W - 1);
    mdl_step   = 1 << (CODE_W - 2);
    mdl_track  = 1'b0;
    mdl_sticky = 1'b0;
    hist.delete();
  endtask

  // Length of the trailing run of direction reversals, capped at LOCK_CNT.
  function automatic int trail_alt();
    int n = 0;
    for (int i = hist.size() - 1; i > 0; i--) begin
      if (hist[i] != hist[i-1]) n++;
      else break;
    end
    return (n > LOCK_CNT) ? LOCK_CNT : n;
  endfunction

  function automatic bit mdl_lock();
`ifdef DCO_CTRL_LOCK_LOSS_EN
    return (hist.size() > 0) && (trail_alt() == LOCK_CNT);
`else
    return mdl_sticky;
`endif
  endfunction

  task automatic mdl_decide(input bit fast);
    if (!mdl_track) begin
      mdl_code = fast ? mdl_code - mdl_step : mdl_code + mdl_step;
      if (mdl_step == 1) mdl_track = 1'b1;
      mdl_step = mdl_step / 2;
    end else begin
      if (fast) mdl_code = (mdl_code > 0) ? mdl_code - 1 : 0;
      else      mdl_code = (mdl_code < CODE_MAX) ? mdl_code + 1 : CODE_MAX;
      hist.push_back(fast);
      if (trail_alt() == LOCK_CNT) mdl_sticky = 1'b1;
    end
  endtask

  // One REF_CLK cycle of stimulus; the model follows the DUT's priority rules.
  task automatic cyc(input bit r, input bit pv, input bit pf, input bit [2:0] m);
    rst          = r;
    bus.PD_VALID = pv;
    bus.PD_FAST  = pf;
    {bus.M2, bus.M1, bus.M0} = m;
    cur_m = m;
    @(negedge clk);
    if (r || (m != mdl_m)) begin
      mdl_reset();
      mdl_m = m;
    end else if (pv) begin
      mdl_decide(pf);
    end
    rst          = 1'b0;
    bus.PD_VALID = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    cyc(1'b1, 1'b0, 1'b0, 3'b010);
    cyc(1'b1, 1'b0, 1'b0, 3'b010);
    vectors++;
    if (bus.DCO_CODE !== 8'h80 || bus.LOCK !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: code=%h lock=%b expected code=80 lock=0", bus.DCO_CODE, bus.LOCK);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 3'b010);
      vectors++;
      if (bus.DCO_CODE !== 8'h80 || bus.LOCK !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_idle[%0d]: code=%h lock=%b expected code=80 lock=0", i, bus.DCO_CODE, bus.LOCK);
      end
    end
  endtask

  task automatic test_search();
    logic [7:0] exp_codes [7] = '{8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
    for (int i = 0; i < 7; i++) begin
      cyc(1'b0, 1'b1, mdl_code > 'hA5, cur_m);
      vectors++;
      if (bus.DCO_CODE !== exp_codes[i] || bus.LOCK !== 1'b0) begin
        miscompares++;
        $display("FAIL search[%0d]: code=%h lock=%b expected code=%h lock=0", i, bus.DCO_CODE, bus.LOCK, exp_codes[i]);
      end
    end
  endtask

  task automatic test_lock();
    logic [7:0] exp_codes [5] = '{8'hA6, 8'hA5, 8'hA6, 8'hA5, 8'hA6};
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1, mdl_code > 'hA5, cur_m);
      vectors++;
      if (bus.DCO_CODE !== exp_codes[i] || bus.LOCK !== (i == 4)) begin
        miscompares++;
        $display("FAIL lock[%0d]: code=%h lock=%b expected code=%h lock=%b", i, bus.DCO_CODE, bus.LOCK, exp_codes[i], i == 4);
      end
    end
  endtask

  task automatic test_lock_loss();
    bit exp_lock;
`ifdef DCO_CTRL_LOCK_LOSS_EN
    exp_lock = 1'b0;
`else
    exp_lock = 1'b1;
`endif
    // Last track decision was upward (A5 -> A6); repeat it.
    cyc(1'b0, 1'b1, 1'b0, cur_m);
    vectors++;
    if (bus.DCO_CODE !== 8'hA7 || bus.LOCK !== exp_lock) begin
      miscompares++;
      $display("FAIL lock_loss: code=%h lock=%b expected code=a7 lock=%b", bus.DCO_CODE, bus.LOCK, exp_lock);
    end
  endtask

  task automatic test_m_change();
    int n = 0;
    while (!mdl_lock() && n < 20) begin
      cyc(1'b0, 1'b1, mdl_code > 'hA5, cur_m);
      n++;
      vectors++;
      if (bus.DCO_CODE !== 8'(mdl_code) || bus.LOCK !== mdl_lock()) begin
        miscompares++;
        $display("FAIL relock[%0d]: code=%h lock=%b expected code=%h lock=%b", n, bus.DCO_CODE, bus.LOCK, 8'(mdl_code), mdl_lock());
      end
    end
    vectors++;
    if (bus.LOCK !== 1'b1) begin
      miscompares++;
      $display("FAIL relock_done: lock=%b expected 1 after %0d pulses", bus.LOCK, n);
    end
    cyc(1'b0, 1'b1, 1'b1, 3'b011);
    vectors++;
    if (bus.DCO_CODE !== 8'h80 || bus.LOCK !== 1'b0) begin
      miscompares++;
      $display("FAIL m_change: code=%h lock=%b expected code=80 lock=0", bus.DCO_CODE, bus.LOCK);
    end
    cyc(1'b0, 1'b1, 1'b0, 3'b011);
    vectors++;
    if (bus.DCO_CODE !== 8'hC0) begin
      miscompares++;
      $display("FAIL m_change_search: code=%h expected c0", bus.DCO_CODE);
    end
  endtask

  task automatic test_saturate();
    cyc(1'b1, 1'b0, 1'b0, cur_m);
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, 1'b0, cur_m);
    vectors++;
    if (bus.DCO_CODE !== 8'hFF || bus.LOCK !== 1'b0) begin
      miscompares++;
      $display("FAIL sat_search: code=%h lock=%b expected code=ff lock=0", bus.DCO_CODE, bus.LOCK);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 1'b0, cur_m);
      vectors++;
      if (bus.DCO_CODE !== 8'hFF || bus.LOCK !== 1'b0) begin
        miscompares++;
        $display("FAIL sat_hold[%0d]: code=%h lock=%b expected code=ff lock=0", i, bus.DCO_CODE, bus.LOCK);
      end
    end
    for (int i = 0; i < 4; i++) begin
      logic [7:0] ec;
      ec = (i % 2 == 0) ? 8'hFE : 8'hFF;
      cyc(1'b0, 1'b1, (i % 2 == 0), cur_m);
      vectors++;
      if (bus.DCO_CODE !== ec || bus.LOCK !== (i == 3)) begin
        miscompares++;
        $display("FAIL sat_alt[%0d]: code=%h lock=%b expected code=%h lock=%b", i, bus.DCO_CODE, bus.LOCK, ec, i == 3);
      end
    end
    cyc(1'b1, 1'b0, 1'b0, cur_m);
    vectors++;
    if (bus.DCO_CODE !== 8'h80 || bus.LOCK !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_track: code=%h lock=%b expected code=80 lock=0", bus.DCO_CODE, bus.LOCK);
    end
  endtask

  task automatic test_random();
    int       tgt;
    bit       r, pv, pf;
    bit [2:0] m;
    tgt = $urandom_range(0, CODE_MAX);
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 199) == 0);
      pv = ($urandom_range(0, 9) < 7);
      pf = ($urandom_range(0, 3) == 0) ? 1'($urandom) : (mdl_code > tgt);
      m  = ($urandom_range(0, 99) < 2) ? 3'($urandom) : cur_m;
      if (r || m != cur_m) tgt = $urandom_range(0, CODE_MAX);
      cyc(r, pv, pf, m);
      vectors++;
      if (bus.DCO_CODE !== 8'(mdl_code) || bus.LOCK !== mdl_lock()) begin
        miscompares++;
        $display("FAIL random[%0d]: code=%h lock=%b expected code=%h lock=%b", i, bus.DCO_CODE, bus.LOCK, 8'(mdl_code), mdl_lock());
      end
    end
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    rst          = 1'b1;
    bus.PD_VALID = 1'b0;
    bus.PD_FAST  = 1'b0;
    {bus.M2, bus.M1, bus.M0} = 3'b010;
    cur_m = 3'b010;
    mdl_m = 3'b010;
    mdl_reset();
    @(negedge clk);
    test_reset();
    test_search();
    test_lock();
    test_lock_loss();
    test_m_change();
    test_saturate();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dco_code_ctrl.md
# dco_code_ctrl

Digital loop controller that sits directly upstream of the DCO inside the ADPLL, clocked by REF_CLK. It consumes one fast/slow decision per comparison interval from the phase/frequency detector and produces the DCO control code. It first binary-searches the code, then tracks it with ±1 steps, and raises LOCK once the loop dithers steadily. A change on the multiplication-factor pins restarts acquisition.

## Interface
- CODE_W, 8, DCO control code width (≥3)
- LOCK_CNT, 4, consecutive direction alternations required to assert LOCK (1..15)
- REF_CLK  in  1  sole clock; all logic on rising edge
- RESET  in  1  synchronous, active-high reset
- M2, M1, M0  in  1 each  multiplication factor {M2,M1,M0}, quasi-static
- PD_VALID  in  1  one-cycle pulse: PD_FAST holds a valid decision
- PD_FAST  in  1  1 = DCO too fast (decrease code), 0 = too slow (increase code)
- DCO_CODE  out  CODE_W  registered DCO control word, higher = faster
- LOCK  out  1  registered lock indication

## Operation
- Reset values: DCO_CODE = 2^(CODE_W-1) (0x80), step = 2^(CODE_W-2) (0x40), state SEARCH, prev-direction invalid, alternation count 0, LOCK = 0, M register = current M pins.
- States: SEARCH, TRACK. Decisions are processed only on PD_VALID=1; all state holds otherwise.
- SEARCH: PD_FAST=1 → code −= step; else code += step; step >>= 1. The decision applied with step=1 moves to TRACK. This takes exactly CODE_W−1 decisions. The range stays within 1..2^CODE_W−1, so no overflow check is needed.
- TRACK: PD_FAST=1 → code −1 unless code=0; PD_FAST=0 → code +1 unless code=all-ones. A saturated decision still counts as that direction.
- Lock detection runs in TRACK only:
  - The first TRACK decision records direction and sets the count to 0.
  - A later decision opposite to the recorded direction increments the count, saturating at LOCK_CNT.
  - A decision in the same direction clears the count to 0.
  - Every decision updates the recorded direction.
- LOCK asserts when count = LOCK_CNT. Deassertion is governed by the configuration macro.
- M change: {M2,M1,M0} ≠ registered M → registered M updated, full return to reset values except M register. Takes priority over a same-cycle PD_VALID, which is discarded.
- RESET has priority over M change and PD_VALID.

## Timing
- DCO_CODE and LOCK update on the REF_CLK edge that samples PD_VALID=1. They are visible in the following cycle (1-cycle latency).
- Back-to-back PD_VALID pulses are legal. Each is processed independently.
- M change or RESET mid-search or mid-track: code = 0x80 and LOCK = 0 in the cycle after the sampling edge.
- No handshake back to the detector. The detector guarantees DCO settling before issuing PD_VALID.

## Configuration
- DCO_CTRL_LOCK_LOSS_EN defined: LOCK tracks count = LOCK_CNT. The first same-direction repeat clears LOCK on the same edge that clears the count.
- Undefined: LOCK is sticky once set. Only RESET or an M change clears it. Code tracking is unaffected.

## Structure
- Package adpll_pkg:
  - state enum {ST_SEARCH, ST_TRACK}
  - CODE_W default
  - mid-code and initial-step constants
- One sub-module, dco_lock_detect: prev-direction register, alternation counter, LOCK output. It is fed by decision-valid, direction and clear inputs.

## Test plan
- RESET held 2 cycles → DCO_CODE=0x80, LOCK=0. No change with PD_VALID idle.
- Bench comparator PD_FAST=(code>0xA5), 7 PD_VALID pulses → codes 0xC0,0xA0,0xB0,0xA8,0xA4,0xA6,0xA5. State TRACK, LOCK=0.
- Continue the comparator for 5 more pulses → codes 0xA6,0xA5,0xA6,0xA5,0xA6. LOCK=1 the cycle after the 5th pulse.
- Comparator target 0xFF → search ends at 0xFF. Further PD_FAST=0 pulses keep 0xFF. Alternating afterwards gives 0xFE/0xFF and LOCK after 5 track decisions.
- While locked, change M from 3'b010 to 3'b011 together with a PD_VALID → next cycle DCO_CODE=0x80, LOCK=0, SEARCH. The pulse is ignored.
- While locked, repeat the previous direction once → with DCO_CTRL_LOCK_LOSS_EN LOCK=0 next cycle; without it LOCK stays 1.
